program_loader: RTL and testbench



---
 rtl/loader_pkg.sv | 19 +
 rtl/byte_assembler.sv | 38 +++
 rtl/program_loader.sv | 107 ++++++++++
 tb/tb_program_loader.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and helpers for the program loader: FSM state encoding,
// header length and the word-index to byte-address mapping.
package loader_pkg;

   typedef enum logic [2:0] {
      WAIT_LEN,
      LOAD,
      WRITE,
      DONE,
      ERROR
   } loader_state_t;

   localparam int LEN_BYTES = 4;

   function automatic logic [31:0] word_to_byte_addr(input logic [29:0] word_idx);
      return {word_idx, 2'b00};
   endfunction

endpackage

// File: rtl/byte_assembler.sv
// Collects bytes into a little-endian 32-bit word; word_out already contains
// the byte being strobed so the caller can capture it on the completing edge.
module byte_assembler
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clear,
   input  logic [7:0]  byte_in,
   input  logic        byte_strobe,
   output logic [31:0] word_out,
   output logic        word_complete
);

   localparam int CNT_W = $clog2(LEN_BYTES);

   logic [CNT_W-1:0] byte_cnt;
   logic [31:0]      word_q;

   always_comb begin
      word_out = word_q;
      if (byte_strobe) begin
         word_out[{byte_cnt, 3'b000} +: 8] = byte_in;
      end
      word_complete = byte_strobe && (byte_cnt == CNT_W'(LEN_BYTES - 1));
   end

   always_ff @(posedge clk) begin
      if (!reset_n || clear) begin
         byte_cnt <= '0;
         word_q   <= '0;
      end else if (byte_strobe) begin
         byte_cnt <= byte_cnt + 1'b1;
         word_q   <= word_out;
      end
   end

endmodule

// File: rtl/program_loader.sv
// Receives a length-prefixed byte image, writes it word by word into the
// instruction memory from address 0, and holds the CPU in reset until done.
module program_loader
   import loader_pkg::*;
#(
   parameter int MEM_WORDS = 256
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   input  logic        start,
   output logic [31:0] mem_byte_address,
   output logic        mem_write_enable,
   output logic [31:0] mem_write_data,
   output logic        cpu_hold,
   output logic        load_done,
   output logic        load_error
);

   localparam int IDX_W = $clog2(MEM_WORDS) + 1;

   loader_state_t    state, state_nxt;
   logic [IDX_W-1:0] word_idx, len_q, idx_inc;
   logic [31:0]      addr_q, data_q, word_out;
   logic             rx_fire, word_complete, asm_clear;

   // Handshake: a byte moves on any edge where rx_valid && rx_ready; rx_ready
   // depends only on state, so the host may raise or drop rx_valid at will.
   assign rx_ready = (state == WAIT_LEN) || (state == LOAD);
   assign rx_fire  = rx_valid && rx_ready;
   assign idx_inc  = word_idx + 1'b1;

   byte_assembler u_asm (
      .clk           (clk),
      .reset_n       (reset_n),
      .clear         (asm_clear),
      .byte_in       (rx_data),
      .byte_strobe   (rx_fire),
      .word_out      (word_out),
      .word_complete (word_complete)
   );

   always_comb begin
      state_nxt = state;
      asm_clear = 1'b0;
      case (state)
         WAIT_LEN: begin
            if (word_complete) begin
               // Full 32-bit compare so large headers cannot alias into range.
               if (word_out == '0)                   state_nxt = DONE;
               else if (word_out > 32'(MEM_WORDS))   state_nxt = ERROR;
               else                                  state_nxt = LOAD;
            end
         end
         LOAD: begin
            if (word_complete) state_nxt = WRITE;
         end
         WRITE: begin
            state_nxt = (idx_inc == len_q) ? DONE : LOAD;
         end
         DONE, ERROR: begin
            if (start) begin
               state_nxt = WAIT_LEN;
               asm_clear = 1'b1;
            end
         end
         default: state_nxt = WAIT_LEN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= WAIT_LEN;
         word_idx <= '0;
         len_q    <= '0;
         addr_q   <= '0;
         data_q   <= '0;
      end else begin
         state <= state_nxt;
         if (state == WAIT_LEN && word_complete) begin
            len_q    <= word_out[IDX_W-1:0];
            word_idx <= '0;
         end
         if (state == LOAD && word_complete) begin
            data_q <= word_out;
            addr_q <= word_to_byte_addr(30'(word_idx));
         end
         if (state == WRITE) begin
            word_idx <= idx_inc;
         end
         if ((state == DONE || state == ERROR) && start) begin
            word_idx <= '0;
            len_q    <= '0;
         end
      end
   end

   assign mem_byte_address = addr_q;
   assign mem_write_data   = data_q;
   assign mem_write_enable = (state == WRITE);
   assign cpu_hold         = (state != DONE);
   assign load_done        = (state == DONE);
   assign load_error       = (state == ERROR);

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: image streams with and without rx_valid
// gaps, length boundaries, error recovery, start handling and mid-load reset.
module tb_program_loader;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        start;
   logic [31:0] mem_byte_address;
   logic        mem_write_enable;
   logic [31:0] mem_write_data;
   logic        cpu_hold;
   logic        load_done;
   logic        load_error;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_writes = 0;
   logic [31:0] last_addr;
   logic [63:0] exp_q[$];
   logic [31:0] img[256];

   always #5 clk = ~clk;

   program_loader #(.MEM_WORDS(256)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .rx_data          (rx_data),
      .rx_valid         (rx_valid),
      .rx_ready         (rx_ready),
      .start            (start),
      .mem_byte_address (mem_byte_address),
      .mem_write_enable (mem_write_enable),
      .mem_write_data   (mem_write_data),
      .cpu_hold         (cpu_hold),
      .load_done        (load_done),
      .load_error       (load_error)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Scoreboard: every write strobe must match the head of the expected queue.
   always @(negedge clk) begin
      if (mem_write_enable === 1'b1) begin
         n_writes++;
         last_addr = mem_byte_address;
         check_eq("write_expected", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0)
            check_eq("write_addr_data", {mem_byte_address, mem_write_data}, exp_q.pop_front());
      end
   end

   task automatic send_byte(input logic [7:0] b, input bit stall);
      int guard;
      if (stall) begin
         while ($urandom_range(0, 1) == 1) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            @(posedge clk); #1;
         end
      end
      rx_data  = b;
      rx_valid = 1'b1;
      guard    = 0;
      while (rx_ready !== 1'b1 && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard == 50) check_eq("rx_ready_timeout", 64'(rx_ready), 64'd1);
      @(posedge clk); #1;
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
   endtask

   task automatic send_length(input logic [31:0] n, input bit stall);
      for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], stall);
   endtask

   task automatic send_data_word(input int idx, input logic [31:0] w, input bit stall);
      exp_q.push_back({32'(idx * 4), w});
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], stall);
      check_eq("we_after_4th", 64'(mem_write_enable), 64'd1);
      check_eq("rdy_in_write", 64'(rx_ready), 64'd0);
   endtask

   task automatic expect_done(input int n);
      if (n != 0) begin
         @(posedge clk); #1;
      end
      check_eq("done_load_done", 64'(load_done), 64'd1);
      check_eq("done_cpu_hold", 64'(cpu_hold), 64'd0);
      check_eq("done_rx_ready", 64'(rx_ready), 64'd0);
      check_eq("done_we", 64'(mem_write_enable), 64'd0);
      check_eq("exp_q_drained", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic load_image(input int n, input bit stall);
      send_length(32'(n), stall);
      for (int i = 0; i < n; i++) send_data_word(i, img[i], stall);
      expect_done(n);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   initial begin
      reset_n  = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      start    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_cpu_hold", 64'(cpu_hold), 64'd1);
      check_eq("rst_load_done", 64'(load_done), 64'd0);
      check_eq("rst_load_error", 64'(load_error), 64'd0);
      check_eq("rst_we", 64'(mem_write_enable), 64'd0);
      check_eq("rst_addr", 64'(mem_byte_address), 64'd0);
      check_eq("rst_data", 64'(mem_write_data), 64'd0);
      reset_n = 1'b1;
      @(posedge clk); #1;
      check_eq("wait_len_ready", 64'(rx_ready), 64'd1);

      // Three-word image, rx_valid held high.
      img[0] = 32'h0000_0013; img[1] = 32'hDEAD_BEEF; img[2] = 32'h1234_5678;
      load_image(3, 1'b0);
      check_eq("img3_last_addr", 64'(last_addr), 64'h8);
      pulse_start();

      // Two words with random rx_valid gaps.
      img[0] = 32'hCAFE_F00D; img[1] = 32'h0BAD_C0DE;
      load_image(2, 1'b1);
      pulse_start();

      // 257 words is one too many.
      n_writes = 0;
      send_length(32'h0000_0101, 1'b0);
      check_eq("err_load_error", 64'(load_error), 64'd1);
      check_eq("err_cpu_hold", 64'(cpu_hold), 64'd1);
      check_eq("err_rx_ready", 64'(rx_ready), 64'd0);
      repeat (5) @(posedge clk);
      #1;
      check_eq("err_no_writes", 64'(n_writes), 64'd0);
      pulse_start();
      check_eq("err_cleared", 64'(load_error), 64'd0);
      check_eq("err_rearm_ready", 64'(rx_ready), 64'd1);
      check_eq("err_rearm_hold", 64'(cpu_hold), 64'd1);

      // Upper header bits must not be truncated away.
      send_length(32'h0100_0001, 1'b0);
      check_eq("err_upper_bits", 64'(load_error), 64'd1);
      pulse_start();

      // Empty image.
      n_writes = 0;
      load_image(0, 1'b0);
      check_eq("len0_no_writes", 64'(n_writes), 64'd0);
      pulse_start();

      // Full memory.
      for (int i = 0; i < 256; i++) img[i] = (32'(i) * 32'h0101_0101) ^ 32'hA500_0000;
      n_writes = 0;
      load_image(256, 1'b0);
      check_eq("full_write_count", 64'(n_writes), 64'd256);
      check_eq("full_last_addr", 64'(last_addr), 64'h3FC);
      pulse_start();

      // start during LOAD must be ignored.
      send_length(32'd1, 1'b0);
      exp_q.push_back({32'h0, 32'h8877_6655});
      send_byte(8'h55, 1'b0);
      send_byte(8'h66, 1'b0);
      pulse_start();
      check_eq("start_in_load_ready", 64'(rx_ready), 64'd1);
      check_eq("start_in_load_done", 64'(load_done), 64'd0);
      send_byte(8'h77, 1'b0);
      send_byte(8'h88, 1'b0);
      check_eq("start_in_load_we", 64'(mem_write_enable), 64'd1);
      expect_done(1);

      // start in DONE re-arms and a new image overwrites from 0x0.
      pulse_start();
      check_eq("rearm_cpu_hold", 64'(cpu_hold), 64'd1);
      check_eq("rearm_load_done", 64'(load_done), 64'd0);
      img[0] = 32'h55AA_55AA;
      load_image(1, 1'b0);
      check_eq("rearm_addr", 64'(last_addr), 64'h0);
      pulse_start();

      // Reset in the middle of the second word.
      send_length(32'd2, 1'b0);
      send_data_word(0, 32'h0F0E_0D0C, 1'b0);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      reset_n = 1'b0;
      @(posedge clk); #1;
      check_eq("midrst_cpu_hold", 64'(cpu_hold), 64'd1);
      check_eq("midrst_we", 64'(mem_write_enable), 64'd0);
      check_eq("midrst_addr", 64'(mem_byte_address), 64'd0);
      check_eq("midrst_data", 64'(mem_write_data), 64'd0);
      check_eq("midrst_done", 64'(load_done), 64'd0);
      check_eq("midrst_error", 64'(load_error), 64'd0);
      reset_n = 1'b1;
      img[0] = 32'h0403_0201;
      load_image(1, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      check_eq("final_exp_q_empty", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
